// File: rtl/seg_scan_ctrl_if.sv
// Load/busy handshake bundle between the counter datapath
// and the seven-segment scan controller.
interface seg_scan_ctrl_if #(
  parameter int VAL_W = 8
);
  logic             load_i;
  logic [VAL_W-1:0] value_i;
  logic             busy_o;

  modport master (
    output load_i,
    output value_i,
    input  busy_o
  );

  modport slave (
    input  load_i,
    input  value_i,
    output busy_o
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: double-dabble BCD conversion plus
// blanked digit multiplexing. Optional macro: SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int VAL_W    = 8,
  parameter int NDIG     = 3,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_ctrl_if.slave   bus,
  output logic [7:0]       seg_o,
  output logic [NDIG-1:0]  dig_o
);

  localparam int CW = $clog2(VAL_W + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = ($clog2(NDIG) > 0) ? $clog2(NDIG) : 1;
  localparam int BW = 4 * NDIG;

  if (longint'(10) ** NDIG <= (longint'(1) << VAL_W)) begin : g_ndig_chk
    $error("seg_scan_ctrl: NDIG too small for VAL_W");
  end
  if (SCAN_DIV < 4) begin : g_div_chk
    $error("seg_scan_ctrl: SCAN_DIV must be at least 4");
  end
  if (BLANK >= SCAN_DIV) begin : g_blank_chk
    $error("seg_scan_ctrl: BLANK must be less than SCAN_DIV");
  end

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  state_t state, state_nxt;

  logic [VAL_W-1:0] sh;
  logic [BW-1:0]    bcd, bcd_adj, disp;
  logic [CW-1:0]    cnt;
  logic [NDIG-1:0]  blank_mask, mask_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.busy_o = (state != IDLE);
    unique case (state)
      IDLE:    if (bus.load_i) state_nxt = CONV;
      CONV:    if (cnt == CW'(VAL_W - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Blank every digit above the most-significant non-zero one.
  always_comb begin
    logic nz;
    nz       = 1'b0;
    mask_nxt = '0;
    for (int i = NDIG - 1; i > 0; i--) begin
      nz          = nz | (bcd[4*i +: 4] != 4'd0);
      mask_nxt[i] = ~nz;
    end
  end
`else
  assign mask_nxt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh         <= '0;
      bcd        <= '0;
      cnt        <= '0;
      disp       <= '0;
      blank_mask <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.load_i) begin
            sh  <= bus.value_i;
            bcd <= '0;
            cnt <= '0;
          end
        end
        CONV: begin
          bcd <= (bcd_adj << 1) | BW'(sh[VAL_W-1]);
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
        end
        COMMIT: begin
          disp       <= bcd;
          blank_mask <= mask_nxt;
        end
        default: ;
      endcase
    end
  end

  logic [PW-1:0] presc, presc_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [3:0]    cur, cur_nxt;
  logic          cur_blank, cur_blank_nxt;
  logic          wrap;
  logic [7:0]    seg_nxt;
  logic [NDIG-1:0] dig_nxt;

  function automatic logic [7:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    return 8'b0000_0011;
      4'd1:    return 8'b1001_1111;
      4'd2:    return 8'b0010_0101;
      4'd3:    return 8'b0000_1101;
      4'd4:    return 8'b1001_1001;
      4'd5:    return 8'b0100_1001;
      4'd6:    return 8'b0100_0001;
      4'd7:    return 8'b0001_1111;
      4'd8:    return 8'b0000_0001;
      4'd9:    return 8'b0000_1001;
      default: return 8'hFF;
    endcase
  endfunction

  // Digit is latched at slot entry so a commit never tears a slot.
  always_comb begin
    wrap          = (presc == PW'(SCAN_DIV - 1));
    presc_nxt     = wrap ? '0 : presc + 1'b1;
    idx_nxt       = idx;
    cur_nxt       = cur;
    cur_blank_nxt = cur_blank;
    if (wrap) begin
      idx_nxt       = (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      cur_nxt       = disp[4*idx_nxt +: 4];
      cur_blank_nxt = blank_mask[idx_nxt];
    end
    seg_nxt = 8'hFF;
    dig_nxt = '1;
    if (presc_nxt >= PW'(BLANK) && !cur_blank_nxt) begin
      dig_nxt[idx_nxt] = 1'b0;
      seg_nxt          = dec(cur_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      idx       <= '0;
      cur       <= '0;
      cur_blank <= 1'b0;
      seg_o     <= 8'hFF;
      dig_o     <= '1;
    end else begin
      presc     <= presc_nxt;
      idx       <= idx_nxt;
      cur       <= cur_nxt;
      cur_blank <= cur_blank_nxt;
      seg_o     <= seg_nxt;
      dig_o     <= dig_nxt;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Display controller for a multi-digit common-anode seven-segment module with one shared segment bus.
- Accepts a binary value through a load/busy handshake.
- Converts the value to BCD sequentially using shift-add-3 (double-dabble), one bit per cycle.
- Time-multiplexes the digits onto the shared bus with a prescaled scan and an anti-ghosting blank interval.
- Sits between the counter datapath and the board display pins.

Parameters:
VAL_W, 8, width of binary input value
NDIG, 3, number of digits; 10^NDIG must exceed 2^VAL_W (elaboration error otherwise)
SCAN_DIV, 50000, clk cycles per digit slot; minimum 4
BLANK, 16, cycles at the start of each slot with all digits off; must be less than SCAN_DIV

Ports:
clk  in  1  system clock, all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
load_i  in  1  request to convert value_i; sampled only in IDLE
value_i  in  VAL_W  binary value to display
busy_o  out  1  high while a conversion is in progress
seg_o  out  8  segments, active-low; bit7=a ... bit1=g, bit0=dp
dig_o  out  NDIG  digit enables, active-low one-hot; bit0=units

Behaviour:
- Reset (async assert, sync release):
  - busy_o=0, seg_o=8'hFF, dig_o all 1.
  - Display register = all digits 0; prescaler=0; slot index=0; FSM=IDLE.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: when load_i=1, capture value_i into a shift register, clear the BCD scratch, set busy_o=1, go to CONV.
  - CONV: runs exactly VAL_W cycles. Each cycle: add 3 to every scratch nibble >=5, then shift left one bit, with the value MSB entering.
  - COMMIT: copy the scratch to the display register in one cycle, then go to IDLE with busy_o=0 in the same cycle.
- Timing:
  - busy_o is high for VAL_W+1 cycles after the load edge.
  - The new digits reach seg_o at the next slot boundary of the matching digit.
  - The display register never changes except in COMMIT, so there are no partial values on the display.
- load_i while busy_o=1 is ignored; it is not queued.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - At wrap, the slot index advances 0,1,...,NDIG-1,0.
  - Prescaler < BLANK: dig_o all 1, seg_o=8'hFF.
  - Otherwise: dig_o has only bit[index]=0, and seg_o is the decoded digit[index].
  - seg_o and dig_o are both registered and change in the same cycle.
- Decode, digit -> seg_o:
  - 0 00000011, 1 10011111, 2 00100101, 3 00001101, 4 10011001
  - 5 01001001, 6 01000001, 7 00011111, 8 00000001, 9 00001001
  - any other code -> 8'hFF
- The scan runs continuously and independently of the FSM, including during CONV.
- Reset mid-conversion: the conversion is abandoned and the display returns to 0s.

Optional Feature:
SEG_SCAN_LZB_EN: leading-zero blanking.
- Defined:
  - At COMMIT, a blank mask is latched for every digit above the most-significant non-zero digit.
  - Blanked slots hold dig_o all 1 and seg_o=8'hFF for the whole slot.
  - The units digit is never blanked, so value 0 shows a single "0".
- Undefined: all NDIG digits are always driven, with leading zeros shown.

Test Plan:
- Reset: assert rst_n=0 mid-slot -> seg_o=8'hFF, dig_o=3'b111 and busy_o=0 immediately. After release, the first BLANK cycles remain off, then slot 0 shows seg_o=8'b00000011 with dig_o=3'b110.
- Conversion: load_i pulse with value_i=42 -> busy_o high exactly 9 cycles. Units slot seg_o=8'b00100101, tens slot 8'b10011001, hundreds slot 8'b00000011.
- Maximum value and ignored load: load 255 -> digits 5,5,2. A load of 17 pulsed during busy is ignored; the display still shows 255 and busy_o drops on schedule.
- Scan timing: with SCAN_DIV=8, BLANK=2 -> dig_o repeats 111,111,110x6, 111,111,101x6, 111,111,011x6. Period is 24 cycles with no two digits enabled together.
- Reset mid-conversion: assert rst_n during CONV of 99 -> busy_o=0 at once. The display shows 000 and the next load of 5 converts correctly.
- Leading-zero blanking (SEG_SCAN_LZB_EN defined): load 7 -> hundreds and tens slots all off, units 8'b00011111. Load 0 -> units shows 8'b00000011 only.
